// File: rtl/gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gemm_tile_scheduler
// Purpose  : Tile-level sequencer for a RowPar x ColPar output-stationary MAC
//            array. Walks output tiles (m outer, n inner, k innermost), issues
//            one A/B SRAM word address pair per cycle, and drives the MAC
//            valid/init/clear controls plus the C write address, enable and
//            edge masks for partial tiles.
// Ports    : clk_i, rst_i (sync, active-high), start_i, M/K/N_size_i
//            sram_a_addr_o, sram_b_addr_o      read addresses (issue cycle)
//            mac_valid_o, acc_init_o           issue + 1
//            sram_c_we_o, sram_c_addr_o,
//            row_valid_o, col_valid_o          issue of last k + 2
//            acc_clr_o, busy_o, done_o         status / control
//            perf_cycles_o, perf_tiles_o       counters (GEMM_SCHED_PERF_EN)
// Config   : GEMM_SCHED_PERF_EN enables the busy-cycle and tile counters;
//            without it both perf ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_tile_scheduler #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16,
  parameter int RowPar        = 4,
  parameter int ColPar        = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     mac_valid_o,
  output logic                     acc_init_o,
  output logic                     acc_clr_o,
  output logic [RowPar-1:0]        row_valid_o,
  output logic [ColPar-1:0]        col_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              perf_cycles_o,
  output logic [15:0]              perf_tiles_o
);

  // Tile counters and remaining-extent registers carry one extra bit so that
  // ceil(255/RowPar) style values and full sizes fit without wrapping.
  localparam int c_cnt_w     = SizeAddrWidth + 1;
  localparam int c_row_shift = $clog2(RowPar);
  localparam int c_col_shift = $clog2(ColPar);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]               r_state;
  logic                     r_drain_cnt;
  logic [SizeAddrWidth-1:0] r_m_size, r_k_size, r_n_size;

  logic [SizeAddrWidth-1:0] r_k;
  logic [c_cnt_w-1:0]       r_m_tile, r_n_tile;
  logic [c_cnt_w-1:0]       r_m_rem, r_n_rem;   // M - m_tile*RowPar, N - n_tile*ColPar
  logic [AddrWidth-1:0]     r_tile_idx;
  logic [AddrWidth-1:0]     r_a_base, r_b_base; // m_tile*K, n_tile*K
  logic [AddrWidth-1:0]     r_a_addr, r_b_addr;

  logic [c_cnt_w-1:0]       w_mt, w_nt;
  logic                     w_issue, w_last_k, w_last_n, w_last_m, w_zero;
  logic [AddrWidth-1:0]     w_k_ext;
  logic [RowPar-1:0]        w_row_mask;
  logic [ColPar-1:0]        w_col_mask;

  // Read-latency and MAC-register alignment pipeline.
  logic                     r_p1_valid, r_p1_init, r_p1_last;
  logic [AddrWidth-1:0]     r_p1_c_addr;
  logic [RowPar-1:0]        r_p1_row;
  logic [ColPar-1:0]        r_p1_col;
  logic                     r_c_we;
  logic [AddrWidth-1:0]     r_c_addr;
  logic [RowPar-1:0]        r_row_valid;
  logic [ColPar-1:0]        r_col_valid;

  assign w_mt = ({1'b0, r_m_size} + c_cnt_w'(RowPar - 1)) >> c_row_shift;
  assign w_nt = ({1'b0, r_n_size} + c_cnt_w'(ColPar - 1)) >> c_col_shift;

  assign w_issue  = (r_state == c_run);
  assign w_last_k = (r_k == r_k_size - SizeAddrWidth'(1));
  assign w_last_n = (r_n_tile == w_nt - c_cnt_w'(1));
  assign w_last_m = (r_m_tile == w_mt - c_cnt_w'(1));
  assign w_k_ext  = AddrWidth'(r_k_size);
  assign w_zero   = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

  for (genvar i = 0; i < RowPar; i++) begin : g_row_mask
    assign w_row_mask[i] = (r_m_rem > c_cnt_w'(i));
  end

  for (genvar j = 0; j < ColPar; j++) begin : g_col_mask
    assign w_col_mask[j] = (r_n_rem > c_cnt_w'(j));
  end

  // Control FSM and loop nest. Address registers are advanced directly so the
  // next issue is ready at the edge, using base registers instead of m*K/n*K.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= c_idle;
      r_drain_cnt <= 1'b0;
      r_m_size    <= '0;
      r_k_size    <= '0;
      r_n_size    <= '0;
      r_k         <= '0;
      r_m_tile    <= '0;
      r_n_tile    <= '0;
      r_m_rem     <= '0;
      r_n_rem     <= '0;
      r_tile_idx  <= '0;
      r_a_base    <= '0;
      r_b_base    <= '0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start_i) begin
            r_m_size   <= M_size_i;
            r_k_size   <= K_size_i;
            r_n_size   <= N_size_i;
            r_k        <= '0;
            r_m_tile   <= '0;
            r_n_tile   <= '0;
            r_m_rem    <= {1'b0, M_size_i};
            r_n_rem    <= {1'b0, N_size_i};
            r_tile_idx <= '0;
            r_a_base   <= '0;
            r_b_base   <= '0;
            r_a_addr   <= '0;
            r_b_addr   <= '0;
            r_state    <= w_zero ? c_done : c_run;
          end
        end
        c_run: begin
          if (!w_last_k) begin
            r_k      <= r_k + SizeAddrWidth'(1);
            r_a_addr <= r_a_addr + AddrWidth'(1);
            r_b_addr <= r_b_addr + AddrWidth'(1);
          end else begin
            r_k        <= '0;
            r_tile_idx <= r_tile_idx + AddrWidth'(1);
            if (!w_last_n) begin
              // Next column tile of the same row band: A restarts at the band base.
              r_n_tile <= r_n_tile + c_cnt_w'(1);
              r_n_rem  <= r_n_rem - c_cnt_w'(ColPar);
              r_b_base <= r_b_base + w_k_ext;
              r_b_addr <= r_b_base + w_k_ext;
              r_a_addr <= r_a_base;
            end else begin
              r_n_tile <= '0;
              r_n_rem  <= {1'b0, r_n_size};
              r_b_base <= '0;
              r_b_addr <= '0;
              if (!w_last_m) begin
                r_m_tile <= r_m_tile + c_cnt_w'(1);
                r_m_rem  <= r_m_rem - c_cnt_w'(RowPar);
                r_a_base <= r_a_base + w_k_ext;
                r_a_addr <= r_a_base + w_k_ext;
              end else begin
                r_state     <= c_drain;
                r_drain_cnt <= 1'b0;
              end
            end
          end
        end
        c_drain: begin
          // Two cycles: let the final tile's data cross the read and MAC stages.
          if (r_drain_cnt) begin
            r_state <= c_done;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Stage 1 aligns with SRAM read data; stage 2 aligns with the registered
  // MAC outputs, which is when the finished tile can be written to C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p1_valid  <= 1'b0;
      r_p1_init   <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p1_c_addr <= '0;
      r_p1_row    <= '0;
      r_p1_col    <= '0;
      r_c_we      <= 1'b0;
      r_c_addr    <= '0;
      r_row_valid <= '0;
      r_col_valid <= '0;
    end else begin
      r_p1_valid  <= w_issue;
      r_p1_init   <= w_issue && (r_k == '0);
      r_p1_last   <= w_issue && w_last_k;
      r_p1_c_addr <= r_tile_idx;
      r_p1_row    <= w_row_mask;
      r_p1_col    <= w_col_mask;
      r_c_we      <= r_p1_last;
      r_c_addr    <= r_p1_last ? r_p1_c_addr : '0;
      r_row_valid <= r_p1_last ? r_p1_row : '0;
      r_col_valid <= r_p1_last ? r_p1_col : '0;
    end
  end

  assign sram_a_addr_o = w_issue ? r_a_addr : '0;
  assign sram_b_addr_o = w_issue ? r_b_addr : '0;
  assign sram_c_addr_o = r_c_addr;
  assign sram_c_we_o   = r_c_we;
  assign row_valid_o   = r_row_valid;
  assign col_valid_o   = r_col_valid;
  assign mac_valid_o   = r_p1_valid;
  assign acc_init_o    = r_p1_init;
  assign acc_clr_o     = (r_state == c_idle) || (r_state == c_done);
  assign busy_o        = (r_state == c_run) || (r_state == c_drain);
  assign done_o        = (r_state == c_done);

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_tiles;

  // Cleared by an accepted start, then held after completion for readout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else if ((r_state == c_idle) && start_i) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else begin
      if (busy_o) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if (r_c_we) begin
        r_perf_tiles <= r_perf_tiles + 16'd1;
      end
    end
  end

  assign perf_cycles_o = r_perf_cycles;
  assign perf_tiles_o  = r_perf_tiles;
`else
  assign perf_cycles_o = '0;
  assign perf_tiles_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_tile_scheduler
// Purpose  : Scoreboard bench for gemm_tile_scheduler. Stimulus pushes the
//            expected issues, C writes and done pulses into queues; a monitor
//            pops and compares whenever the DUT presents mac_valid_o,
//            sram_c_we_o or done_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  m_size, k_size, n_size;
  logic [15:0] a_addr, b_addr, c_addr;
  logic        c_we, mac_valid, acc_init, acc_clr, busy, done;
  logic [3:0]  row_valid;
  logic [15:0] col_valid;
  logic [31:0] perf_cycles;
  logic [15:0] perf_tiles;

  gemm_tile_scheduler #(
    .SizeAddrWidth(8),
    .AddrWidth    (16),
    .RowPar       (4),
    .ColPar       (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .M_size_i     (m_size),
    .K_size_i     (k_size),
    .N_size_i     (n_size),
    .sram_a_addr_o(a_addr),
    .sram_b_addr_o(b_addr),
    .sram_c_addr_o(c_addr),
    .sram_c_we_o  (c_we),
    .mac_valid_o  (mac_valid),
    .acc_init_o   (acc_init),
    .acc_clr_o    (acc_clr),
    .row_valid_o  (row_valid),
    .col_valid_o  (col_valid),
    .busy_o       (busy),
    .done_o       (done),
    .perf_cycles_o(perf_cycles),
    .perf_tiles_o (perf_tiles)
  );

  typedef struct {
    int cyc;
    int a;
    int b;
    bit init;
  } issue_t;

  typedef struct {
    int          cyc;
    int          addr;
    logic [3:0]  row;
    logic [15:0] col;
  } write_t;

  issue_t issue_q[$];
  write_t write_q[$];
  int     done_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares on DUT-presented events, independent of stimulus.
  initial begin : monitor
    logic [15:0] prev_a, prev_b;
    issue_t ei;
    write_t ew;
    int     ed;
    prev_a = '0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (mac_valid === 1'b1) begin
        if (issue_q.size() == 0) begin
          chk("unexpected_issue", 64'(mac_valid), 64'd0);
        end else begin
          ei = issue_q.pop_front();
          chk("issue_cycle", 64'(cyc - 1), 64'(ei.cyc));
          chk("issue_a_addr", 64'(prev_a), 64'(ei.a));
          chk("issue_b_addr", 64'(prev_b), 64'(ei.b));
          chk("issue_acc_init", 64'(acc_init), 64'(ei.init));
        end
      end
      if (c_we === 1'b1) begin
        if (write_q.size() == 0) begin
          chk("unexpected_c_write", 64'(c_we), 64'd0);
        end else begin
          ew = write_q.pop_front();
          chk("c_write_cycle", 64'(cyc), 64'(ew.cyc));
          chk("c_write_addr", 64'(c_addr), 64'(ew.addr));
          chk("c_row_valid", 64'(row_valid), 64'(ew.row));
          chk("c_col_valid", 64'(col_valid), 64'(ew.col));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          ed = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ed));
        end
      end
      prev_a = a_addr;
      prev_b = b_addr;
    end
  end

  task automatic start_run(input int m, input int k, input int n, output int c0);
    @(posedge clk);
    #1;
    c0     = cyc;
    m_size = 8'(m);
    k_size = 8'(k);
    n_size = 8'(n);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic pulse_start_at(input int c, input int m, input int k, input int n);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    m_size = 8'(m);
    k_size = 8'(k);
    n_size = 8'(n);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
  endtask

  // Expected issue stream from the plain loop nest with explicit products.
  task automatic push_issues(input int c0, input int m, input int k, input int n, input int limit);
    int mt, nt, t, cnt;
    mt  = (m + 3) / 4;
    nt  = (n + 15) / 16;
    t   = c0 + 1;
    cnt = 0;
    for (int mi = 0; mi < mt; mi++) begin
      for (int ni = 0; ni < nt; ni++) begin
        for (int ki = 0; ki < k; ki++) begin
          if (cnt < limit) begin
            issue_q.push_back('{cyc: t, a: mi * k + ki, b: ni * k + ki, init: (ki == 0)});
          end
          t++;
          cnt++;
        end
      end
    end
  endtask

  task automatic push_write(input int c, input int addr, input logic [3:0] row, input logic [15:0] col);
    write_q.push_back('{cyc: c, addr: addr, row: row, col: col});
  endtask

  task automatic drain_check(input int until_cyc);
    at_cycle(until_cyc);
    if (issue_q.size() != 0) begin
      chk("missing_issues", 64'(issue_q.size()), 64'd0);
      issue_q.delete();
    end
    if (write_q.size() != 0) begin
      chk("missing_c_writes", 64'(write_q.size()), 64'd0);
      write_q.delete();
    end
    if (done_q.size() != 0) begin
      chk("missing_done", 64'(done_q.size()), 64'd0);
      done_q.delete();
    end
  endtask

  task automatic chk_perf(input int exp_cycles, input int exp_tiles);
`ifdef GEMM_SCHED_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(exp_cycles));
    chk("perf_tiles", 64'(perf_tiles), 64'(exp_tiles));
`else
    chk("perf_cycles_tied", 64'(perf_cycles), 64'd0 * 64'(exp_cycles));
    chk("perf_tiles_tied", 64'(perf_tiles), 64'd0 * 64'(exp_tiles));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_acc_clr"}, 64'(acc_clr), 64'd1);
    chk({tag, "_mac_valid"}, 64'(mac_valid), 64'd0);
    chk({tag, "_acc_init"}, 64'(acc_init), 64'd0);
    chk({tag, "_c_we"}, 64'(c_we), 64'd0);
    chk({tag, "_addrs"}, {16'd0, a_addr, b_addr, c_addr}, 64'd0);
    chk({tag, "_masks"}, {44'd0, row_valid, col_valid}, 64'd0);
  endtask

  initial begin : stimulus
    int c0;
    rst    = 1'b1;
    start  = 1'b0;
    m_size = '0;
    k_size = '0;
    n_size = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    chk_perf(0, 0);

    // Single full tile; a second start mid-run must be ignored.
    start_run(4, 3, 16, c0);
    push_issues(c0, 4, 3, 16, 1000);
    push_write(c0 + 5, 0, 4'hF, 16'hFFFF);
    done_q.push_back(c0 + 6);
    at_cycle(c0 + 1);
    chk("v1_busy_run", 64'(busy), 64'd1);
    chk("v1_acc_clr_run", 64'(acc_clr), 64'd0);
    pulse_start_at(c0 + 2, 8, 2, 32);
    at_cycle(c0 + 5);
    chk("v1_busy_drain", 64'(busy), 64'd1);
    at_cycle(c0 + 6);
    chk("v1_busy_done", 64'(busy), 64'd0);
    chk("v1_acc_clr_done", 64'(acc_clr), 64'd1);
    drain_check(c0 + 9);
    chk_perf(5, 1);

    // 2x2 tiles, K=2.
    start_run(8, 2, 32, c0);
    push_issues(c0, 8, 2, 32, 1000);
    push_write(c0 + 4,  0, 4'hF, 16'hFFFF);
    push_write(c0 + 6,  1, 4'hF, 16'hFFFF);
    push_write(c0 + 8,  2, 4'hF, 16'hFFFF);
    push_write(c0 + 10, 3, 4'hF, 16'hFFFF);
    done_q.push_back(c0 + 11);
    drain_check(c0 + 14);
    chk_perf(10, 4);

    // Partial edge tiles, K=1: back-to-back writes.
    start_run(5, 1, 17, c0);
    push_issues(c0, 5, 1, 17, 1000);
    push_write(c0 + 3, 0, 4'hF, 16'hFFFF);
    push_write(c0 + 4, 1, 4'hF, 16'h0001);
    push_write(c0 + 5, 2, 4'h1, 16'hFFFF);
    push_write(c0 + 6, 3, 4'h1, 16'h0001);
    done_q.push_back(c0 + 7);
    drain_check(c0 + 10);
    chk_perf(6, 4);

    // K=0: immediate completion, never busy.
    start_run(4, 0, 16, c0);
    done_q.push_back(c0 + 1);
    at_cycle(c0 + 1);
    chk("k0_busy", 64'(busy), 64'd0);
    chk("k0_acc_clr", 64'(acc_clr), 64'd1);
    drain_check(c0 + 5);
    chk_perf(0, 0);

    // Reset in the middle of a run.
    start_run(8, 4, 16, c0);
    push_issues(c0, 8, 4, 16, 2);
    while (cyc < c0 + 3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    at_cycle(c0 + 4);
    chk_reset_outputs("midrst");
    drain_check(c0 + 20);
    chk_perf(0, 0);

    // Fresh run after the reset.
    start_run(8, 4, 16, c0);
    push_issues(c0, 8, 4, 16, 1000);
    push_write(c0 + 6,  0, 4'hF, 16'hFFFF);
    push_write(c0 + 10, 1, 4'hF, 16'hFFFF);
    done_q.push_back(c0 + 11);
    drain_check(c0 + 14);
    chk_perf(10, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gemm_tile_scheduler.md
# gemm_tile_scheduler

Tile-level sequencer for the RowPar x ColPar output-stationary MAC array in the GeMM accelerator. On a start pulse it latches M/K/N, walks all output tiles (m-tile outer, n-tile inner, k innermost), and drives the SRAM A/B read addresses, the MAC valid/init/clear controls, and the SRAM C write address and enable. It handles partial edge tiles with row and column masks. It replaces the flat counter controller, and the MAC grid connects to it unchanged.

## Interface
- SizeAddrWidth, 8: width of M/K/N sizes and of internal loop counters.
- AddrWidth, 16: SRAM address width.
- RowPar, 4: MAC array rows; power of two.
- ColPar, 16: MAC array columns; power of two.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  start pulse; honoured only in IDLE.
- M_size_i / K_size_i / N_size_i  in  SizeAddrWidth each  matrix sizes; sampled when start is accepted.
- sram_a_addr_o  out  AddrWidth  A word address (one word holds RowPar elements of one k column).
- sram_b_addr_o  out  AddrWidth  B word address (one word holds ColPar elements of one k row).
- sram_c_addr_o  out  AddrWidth  C tile address.
- sram_c_we_o  out  1  C write enable.
- mac_valid_o  out  1  SRAM read data is valid this cycle; drives a_valid_i and b_valid_i.
- acc_init_o  out  1  first k of a tile; the accumulator loads the product instead of adding it.
- acc_clr_o  out  1  accumulator clear.
- row_valid_o  out  RowPar  valid rows of the tile being written; aligned with sram_c_we_o.
- col_valid_o  out  ColPar  valid columns of the tile being written; aligned with sram_c_we_o.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- perf_cycles_o  out  32  busy-cycle count; present only with the macro (see Configuration).
- perf_tiles_o  out  16  tiles-written count; present only with the macro (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE + start_i: latch sizes. Go to RUN, or to DONE if any size is 0.
  - RUN: issue one (tile, k) address pair per cycle. After the last k of the last tile, go to DRAIN.
  - DRAIN: lasts exactly 2 cycles, then go to DONE.
  - DONE: lasts 1 cycle, then go to IDLE.
- Tile counts: MT = ceil(M/RowPar), NT = ceil(N/ColPar). Compute them with shifts in SizeAddrWidth+1 bits.
- Address generation uses incrementing base registers; there are no multipliers.
  - sram_a_addr_o = m_tile*K + k.
  - sram_b_addr_o = n_tile*K + k.
  - sram_c_addr_o = m_tile*NT + n_tile, which equals the running tile index.
- Edge masks, where r = M − m_tile*RowPar and c = N − n_tile*ColPar:
  - row_valid_o bit i = (i < r).
  - col_valid_o bit j = (j < c).
  - Both are all-ones for interior tiles and 0 when sram_c_we_o = 0.
- acc_clr_o is 1 in IDLE and DONE and 0 otherwise.
- start_i while not in IDLE is ignored, and the latched sizes do not change.
- rst_i at any point, including mid-RUN or mid-DRAIN, returns to IDLE in the next cycle. No further sram_c_we_o or done_o is produced.
- Reset values:
  - All addresses 0.
  - sram_c_we_o, mac_valid_o, acc_init_o, busy_o, done_o all 0.
  - acc_clr_o 1.
  - row_valid_o and col_valid_o 0.
  - perf counters 0.

## Timing
- SRAM read latency is 1 cycle.
  - An address issued in cycle t gives data in t+1.
  - mac_valid_o is asserted in t+1.
  - acc_init_o is asserted in t+1 when the issued k was 0.
- Tile write: if the last k of a tile is issued in cycle t, then sram_c_we_o, sram_c_addr_o, and the masks are valid in t+2. This reads the MAC outputs registered from the t+1 data.
- Consecutive tiles run with no bubble. The next tile's acc_init_o in t+2 only takes effect at the end of t+2, so the C write in t+2 still sees the completed tile.
- With the start accepted in cycle 0 and T = MT*NT:
  - Issues occur in cycles 1..T*K.
  - The final sram_c_we_o is in cycle T*K+2.
  - done_o is in cycle T*K+3.
  - busy_o is high in cycles 1..T*K+2.
- With a zero size: done_o is in cycle 1, busy_o stays 0, and no writes occur.
- K = 1: every issue is both first and last; acc_init_o and sram_c_we_o occur every cycle, pipelined.

## Configuration
- GEMM_SCHED_PERF_EN defined:
  - perf_cycles_o counts cycles with busy_o = 1.
  - perf_tiles_o counts sram_c_we_o pulses.
  - Both clear on an accepted start and hold their values after done_o until the next start.
- Undefined: both ports are tied to 0 and no counter logic is present.

## Test plan
- M=4, K=3, N=16, start in cycle 0 -> A addresses 0,1,2 and B addresses 0,1,2 in cycles 1–3; acc_init_o in cycle 2; sram_c_we_o at address 0 with full masks in cycle 5; done_o in cycle 6.
- M=8, K=2, N=32 -> A sequence 0,1,0,1,2,3,2,3; B sequence 0,1,2,3,0,1,2,3; C writes to 0,1,2,3 in cycles 4,6,8,10; done_o in cycle 11.
- M=5, K=1, N=17 -> 4 tiles written back to back in cycles 3–6; tile 3 has row_valid_o = 4'b0001 and col_valid_o = 16'h0001; tile 1 has row_valid_o = 4'hF and col_valid_o = 16'h0001.
- K=0 (any M, N) -> done_o in cycle 1, no sram_c_we_o, busy_o never set; a start_i pulsed during a run is ignored.
- rst_i asserted in cycle 3 of an M=8, K=4, N=16 run -> busy_o = 0 and all outputs at reset values from cycle 4; no write or done_o follows; a new start then runs correctly.
- With GEMM_SCHED_PERF_EN, M=8, K=2, N=32 -> perf_cycles_o = 10 and perf_tiles_o = 4 after done_o.
